// File: rtl/obu_parser_pkg.sv
// Shared types and constants for the OBU bitstream parser blocks.
package obu_parser_pkg;

  localparam int PARSER_DATA_WIDTH = 32;
  localparam int BUF_WIDTH         = 2 * PARSER_DATA_WIDTH;
  localparam int CNT_WIDTH         = $clog2(BUF_WIDTH) + 1;
  localparam int LEN_WIDTH         = 6;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } field_seq_state_e;

  // Bits needed to reach the next byte boundary from the given bit offset.
  function automatic logic [2:0] align_bits(input logic [2:0] pos);
    return 3'd0 - pos;
  endfunction

endpackage

// File: rtl/field_sequencer_bit_extract.sv
// Combinational extract of the top len bits of the bit buffer, right-justified.
module bit_extract
  import obu_parser_pkg::*;
(
  input  logic [BUF_WIDTH-1:0]         buf_in,
  input  logic [LEN_WIDTH-1:0]         len,
  output logic [PARSER_DATA_WIDTH-1:0] field
);

  logic [CNT_WIDTH-1:0] shamt;

  // Shift the wanted MSB-side bits down to the bottom; len of 0 yields zero.
  always_comb begin
    shamt = CNT_WIDTH'(BUF_WIDTH) - {1'b0, len};
    field = PARSER_DATA_WIDTH'(buf_in >> shamt);
  end

endmodule

// File: rtl/field_sequencer.sv
// Bit-level field sequencer: buffers upstream words and serves fixed-width
// or byte-align field requests from the front of the bitstream.
module field_sequencer
  import obu_parser_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PARSER_DATA_WIDTH-1:0] word_data,
  input  logic                         word_valid,
  output logic                         word_ready,
  input  logic                         fld_req,
  input  logic [LEN_WIDTH-1:0]         fld_len,
  input  logic                         fld_align,
  output logic                         fld_ready,
  output logic                         fld_valid,
  output logic [PARSER_DATA_WIDTH-1:0] fld_data,
  input  logic                         flush,
  output logic [31:0]                  bit_pos,
  output logic                         err_len
);

  field_seq_state_e state;

  // Buffer is left-aligned: bit BUF_WIDTH-1 is the next bit to consume and
  // every bit below the fill count is kept at zero so appends can OR in.
  logic [BUF_WIDTH-1:0] buffer;
  logic [CNT_WIDTH-1:0] cnt;

  logic                         blocked;
  logic                         word_take;
  logic                         len_bad;
  logic                         is_err;
  logic                         is_align;
  logic [2:0]                   drop_bits;
  logic [CNT_WIDTH-1:0]         consume;
  logic [CNT_WIDTH-1:0]         cnt_left;
  logic [CNT_WIDTH-1:0]         cnt_next;
  logic [BUF_WIDTH-1:0]         buf_left;
  logic [BUF_WIDTH-1:0]         appended;
  logic [BUF_WIDTH-1:0]         buf_next;
  logic [PARSER_DATA_WIDTH-1:0] extracted;

  bit_extract u_bit_extract (
    .buf_in (buffer),
    .len    (fld_len),
    .field  (extracted)
  );

  // Handshake decisions and next buffer contents; acceptance looks only at
  // bits already buffered, and a same-cycle word lands after the removal.
  always_comb begin
    blocked   = flush || (state == FLUSH);
    word_ready = (cnt <= CNT_WIDTH'(PARSER_DATA_WIDTH)) && !blocked;
    word_take = word_ready && word_valid;
    drop_bits = align_bits(bit_pos[2:0]);
    len_bad   = (fld_len == '0) || (fld_len > LEN_WIDTH'(PARSER_DATA_WIDTH));

    fld_ready = 1'b0;
    is_err    = 1'b0;
    is_align  = 1'b0;
    consume   = '0;
    if (fld_req && !blocked) begin
      if (fld_align) begin
        if (cnt >= CNT_WIDTH'(drop_bits)) begin
          fld_ready = 1'b1;
          is_align  = 1'b1;
          consume   = CNT_WIDTH'(drop_bits);
        end
      end else if (len_bad) begin
        fld_ready = 1'b1;
        is_err    = 1'b1;
      end else if (cnt >= {1'b0, fld_len}) begin
        fld_ready = 1'b1;
        consume   = {1'b0, fld_len};
      end
    end

    cnt_left = cnt - consume;
    buf_left = buffer << consume;
    appended = {word_data, {PARSER_DATA_WIDTH{1'b0}}} >> cnt_left;
    if (word_take) begin
      buf_next = buf_left | appended;
      cnt_next = cnt_left + CNT_WIDTH'(PARSER_DATA_WIDTH);
    end else begin
      buf_next = buf_left;
      cnt_next = cnt_left;
    end
  end

  // State, buffer and registered result; flush wins over any acceptance and
  // leaves the last delivered field value in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      buffer    <= '0;
      cnt       <= '0;
      bit_pos   <= '0;
      fld_valid <= 1'b0;
      fld_data  <= '0;
      err_len   <= 1'b0;
    end else if (flush) begin
      state     <= FLUSH;
      buffer    <= '0;
      cnt       <= '0;
      bit_pos   <= '0;
      fld_valid <= 1'b0;
      err_len   <= 1'b0;
    end else begin
      buffer    <= buf_next;
      cnt       <= cnt_next;
      bit_pos   <= bit_pos + 32'(consume);
      fld_valid <= fld_ready;
      err_len   <= is_err;
      if (fld_ready) begin
        fld_data <= (is_err || is_align) ? '0 : extracted;
      end
      state <= (cnt_next == '0) ? EMPTY : RUN;
    end
  end

endmodule

// File: tb/tb_field_sequencer.sv
// Self-checking bench for field_sequencer against a bit-queue reference model.
module tb_field_sequencer;
  import obu_parser_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;
  logic        fld_req;
  logic [5:0]  fld_len;
  logic        fld_align;
  logic        fld_ready;
  logic        fld_valid;
  logic [31:0] fld_data;
  logic        flush;
  logic [31:0] bit_pos;
  logic        err_len;

  int total = 0;
  int bad   = 0;

  // Reference model: the bitstream as a queue of bits, earliest first.
  bit          model_q[$];
  int unsigned m_pos;
  bit          m_in_flush;
  bit          m_valid;
  bit          m_err;
  logic [31:0] m_data;
  bit          last_accept;

  field_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .fld_req    (fld_req),
    .fld_len    (fld_len),
    .fld_align  (fld_align),
    .fld_ready  (fld_ready),
    .fld_valid  (fld_valid),
    .fld_data   (fld_data),
    .flush      (flush),
    .bit_pos    (bit_pos),
    .err_len    (err_len)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive after the falling edge, check handshakes,
  // advance the model at the rising edge, then check registered results.
  task automatic applyStimulus(input bit wv, input logic [31:0] wd, input bit req,
                               input logic [5:0] len, input bit al, input bit fl);
    bit exp_wr;
    bit exp_fr;
    bit err;
    int d;
    int n;
    word_valid = wv;
    word_data  = wd;
    fld_req    = req;
    fld_len    = len;
    fld_align  = al;
    flush      = fl;
    #1;
    n      = int'(len);
    d      = (8 - int'(m_pos % 8)) % 8;
    err    = !al && (n == 0 || n > 32);
    exp_wr = (model_q.size() <= 32) && !fl && !m_in_flush;
    exp_fr = 1'b0;
    if (req && !fl && !m_in_flush) begin
      if (al)       exp_fr = (model_q.size() >= d);
      else if (err) exp_fr = 1'b1;
      else          exp_fr = (model_q.size() >= n);
    end
    checkOutput("word_ready", 32'(word_ready), 32'(exp_wr));
    checkOutput("fld_ready", 32'(fld_ready), 32'(exp_fr));
    last_accept = exp_fr;
    @(posedge clk);
    if (fl) begin
      model_q.delete();
      m_pos      = 0;
      m_in_flush = 1'b1;
      m_valid    = 1'b0;
      m_err      = 1'b0;
    end else begin
      m_in_flush = 1'b0;
      m_valid    = exp_fr;
      m_err      = exp_fr && err;
      if (exp_fr) begin
        m_data = 32'h0;
        if (al) begin
          repeat (d) void'(model_q.pop_front());
          m_pos += d;
        end else if (!err) begin
          for (int i = 0; i < n; i++) m_data = {m_data[30:0], model_q.pop_front()};
          m_pos += n;
        end
      end
      if (wv && exp_wr)
        for (int i = 31; i >= 0; i--) model_q.push_back(wd[i]);
    end
    #1;
    checkOutput("fld_valid", 32'(fld_valid), 32'(m_valid));
    checkOutput("err_len", 32'(err_len), 32'(m_err));
    checkOutput("fld_data", fld_data, m_data);
    checkOutput("bit_pos", bit_pos, m_pos);
    @(negedge clk);
  endtask

  task automatic idleInputs();
    word_valid = 1'b0;
    word_data  = 32'h0;
    fld_req    = 1'b0;
    fld_len    = 6'd0;
    fld_align  = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic resetModel();
    model_q.delete();
    m_pos       = 0;
    m_in_flush  = 1'b0;
    m_valid     = 1'b0;
    m_err       = 1'b0;
    m_data      = 32'h0;
    last_accept = 1'b0;
  endtask

  // Assert reset off the clock edge and confirm outputs clear immediately.
  task automatic doReset(input string tag);
    idleInputs();
    rst = 1'b1;
    #1;
    resetModel();
    checkOutput({tag, "_valid"}, 32'(fld_valid), 32'h0);
    checkOutput({tag, "_data"}, fld_data, 32'h0);
    checkOutput({tag, "_err"}, 32'(err_len), 32'h0);
    checkOutput({tag, "_pos"}, bit_pos, 32'h0);
    checkOutput({tag, "_wready"}, 32'(word_ready), 32'h1);
    checkOutput({tag, "_fready"}, 32'(fld_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit          r_req;
    bit          r_al;
    logic [5:0]  r_len;
    int          pick;

    rst = 1'b0;
    idleInputs();
    resetModel();
    #2;
    doReset("rst0");

    // Nibble, nibble, then the rest of the first word.
    applyStimulus(1'b1, 32'hA500_0000, 1'b0, 6'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b1, 6'd4, 1'b0, 1'b0);
    checkOutput("seq_a", fld_data, 32'hA);
    applyStimulus(1'b0, 32'h0, 1'b1, 6'd4, 1'b0, 1'b0);
    checkOutput("seq_5", fld_data, 32'h5);
    applyStimulus(1'b0, 32'h0, 1'b1, 6'd24, 1'b0, 1'b0);
    checkOutput("seq_0", fld_data, 32'h0);
    checkOutput("seq_pos", bit_pos, 32'd32);

    // Oversized length is flagged without consuming anything.
    applyStimulus(1'b0, 32'h0, 1'b1, 6'd40, 1'b0, 1'b0);
    checkOutput("bad_len_err", 32'(err_len), 32'h1);
    checkOutput("bad_len_data", fld_data, 32'h0);
    checkOutput("bad_len_pos", bit_pos, 32'd32);

    // Full-word read while the next word is appended in the same cycle.
    doReset("rst1");
    applyStimulus(1'b1, 32'h1234_5678, 1'b0, 6'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hCAFE_BABE, 1'b1, 6'd32, 1'b0, 1'b0);
    checkOutput("word32_a", fld_data, 32'h1234_5678);
    applyStimulus(1'b0, 32'h0, 1'b1, 6'd32, 1'b0, 1'b0);
    checkOutput("word32_b", fld_data, 32'hCAFE_BABE);

    // Byte alignment after three bits, then an already-aligned request.
    doReset("rst2");
    applyStimulus(1'b1, 32'hE0FF_0000, 1'b0, 6'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 6'd3, 1'b0, 1'b0);
    checkOutput("align_pre", fld_data, 32'h7);
    applyStimulus(1'b0, 32'h0, 1'b1, 6'd0, 1'b1, 1'b0);
    checkOutput("align_pos", bit_pos, 32'd8);
    applyStimulus(1'b0, 32'h0, 1'b1, 6'd0, 1'b1, 1'b0);
    checkOutput("align0_valid", 32'(fld_valid), 32'h1);
    checkOutput("align0_pos", bit_pos, 32'd8);

    // Short buffer: the request waits until a word has actually landed.
    doReset("rst3");
    applyStimulus(1'b1, 32'h89AB_CDEF, 1'b0, 6'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 6'd27, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 6'd8, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h1234_5678, 1'b1, 6'd8, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 6'd8, 1'b0, 1'b0);
    checkOutput("short_data", fld_data, 32'h78);

    // Reset mid-stream while a result is showing.
    fld_req = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    resetModel();
    checkOutput("async_valid", 32'(fld_valid), 32'h0);
    checkOutput("async_data", fld_data, 32'h0);
    checkOutput("async_pos", bit_pos, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1, 6'd1, 1'b0, 1'b0);

    // Flush with 40 bits held and a request pending.
    doReset("rst4");
    applyStimulus(1'b1, 32'h0F0F_0F0F, 1'b0, 6'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h3C3C_3C3C, 1'b0, 6'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 6'd24, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h5555_5555, 1'b1, 6'd8, 1'b0, 1'b1);
    checkOutput("flush_valid", 32'(fld_valid), 32'h0);
    applyStimulus(1'b1, 32'h5555_5555, 1'b1, 6'd8, 1'b0, 1'b0);
    checkOutput("flush_pos", bit_pos, 32'h0);
    applyStimulus(1'b1, 32'h5555_5555, 1'b0, 6'd0, 1'b0, 1'b0);

    // Randomised traffic; a request stays put until it is accepted.
    r_req = 1'b0;
    r_al  = 1'b0;
    r_len = 6'd0;
    for (int k = 0; k < 400; k++) begin
      if (!r_req || last_accept) begin
        r_req = ($urandom_range(0, 3) != 0);
        r_al  = ($urandom_range(0, 9) == 0);
        pick  = int'($urandom_range(0, 19));
        if (pick == 0)      r_len = 6'd0;
        else if (pick == 1) r_len = 6'($urandom_range(33, 63));
        else                r_len = 6'($urandom_range(1, 32));
      end
      applyStimulus(1'($urandom_range(0, 1)), $urandom, r_req, r_len, r_al,
                    ($urandom_range(0, 39) == 0));
    end

    $display("[TB] directed and random phases complete");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/field_sequencer.md
FIELD_SEQUENCER -- requirements
Module: field_sequencer

Interface
REQ-001 SHALL take PARSER_DATA_WIDTH (=32) from obu_parser_pkg; no local override.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 word_data  in  32  upstream bitstream word, MSB = earliest bit.
REQ-005 word_valid  in  1 / word_ready  out  1  upstream handshake; transfer when both high.
REQ-006 fld_req  in  1  field request; held with its operands until fld_ready.
REQ-007 fld_len  in  6  requested field width in bits, legal 1..32.
REQ-008 fld_align  in  1  with fld_req: byte-align request; fld_len ignored.
REQ-009 fld_ready  out  1  request accepted this cycle (combinational).
REQ-010 fld_valid  out  1 / fld_data  out  32  result pulse; data right-justified, zero-extended.
REQ-011 flush  in  1  discard all buffered bits and reset bit position.
REQ-012 bit_pos  out  32  total bits consumed since reset/flush, wraps modulo 2^32.
REQ-013 err_len  out  1  one-cycle pulse for illegal fld_len.

Function
REQ-014 Internal 64-bit buffer; fill count cnt in 0..64; bits consumed MSB-first.
REQ-015 word_ready SHALL equal (cnt <= 32) && !flush; an accepted word appends directly below the existing cnt bits.
REQ-016 Normal request SHALL be accepted (fld_ready=1) iff cnt >= fld_len, evaluated before this cycle's word append.
REQ-017 On acceptance, the top fld_len bits SHALL be removed; fld_valid=1 and fld_data SHALL be presented the next cycle (latency 1).
REQ-018 Align request: drop d = (8 - bit_pos[2:0]) mod 8 bits; accepted iff cnt >= d; fld_valid pulses with fld_data=0; d=0 accepted immediately.
REQ-019 Simultaneous word accept and field accept: next cnt = cnt - consumed + 32; both SHALL occur in the same cycle.
REQ-020 fld_len = 0 or > 32 (not align): fld_ready=1, err_len=1 and fld_valid=1 next cycle with fld_data=0; no bits consumed; bit_pos unchanged.
REQ-021 bit_pos SHALL increase by the bits consumed on each accepted request.
REQ-022 FSM states: EMPTY (cnt=0), RUN (cnt>0), FLUSH (one cycle after flush). flush from any state -> FLUSH -> EMPTY. EMPTY -> RUN on word accept. RUN -> EMPTY when consumption leaves cnt=0 with no append.
REQ-023 In FLUSH, word_ready=0 and fld_ready=0; flush SHALL override any same-cycle word or field acceptance; a result pending from the previous cycle is still output.
REQ-024 fld_ready SHALL be 0 whenever fld_req=0; no output toggles without a request.

Reset
REQ-025 Asserting rst SHALL immediately clear the buffer, cnt, bit_pos, fld_valid, fld_data and err_len to 0 and set the state to EMPTY.
REQ-026 After reset, word_ready=1 and fld_ready=0; any in-flight result is lost; reset mid-operation SHALL leave no residual bits.

Structure
REQ-027 PARSER_DATA_WIDTH and a field_seq_state_e enum (EMPTY, RUN, FLUSH) SHALL be defined in obu_parser_pkg.
REQ-028 Consumers SHALL use fld_data as fixed-width parsed fields.
REQ-029 Optional sub-module bit_extract: combinational top-N-bit extract from the 64-bit buffer; all other logic is flat.

Verification
REQ-030 Words 0xA5000000 then 0xFFFFFFFF; requests len 4, 4, 24 -> fld_data 0xA, 0x5, 0x000000; bit_pos = 32.
REQ-031 Word 0x12345678; request len 32 in the same cycle a second word arrives -> fld_data 0x12345678 one cycle later; cnt = 32.
REQ-032 Consume 3 bits, then align -> 5 bits dropped, bit_pos = 8; an immediate second align drops 0 and completes in one cycle.
REQ-033 Request len 8 with cnt = 5 and word_valid = 0 -> fld_ready stays 0; raise word_valid -> accepted the next cycle with the correct bits.
REQ-034 fld_len = 40 -> err_len pulse, fld_data = 0, bit_pos unchanged.
REQ-035 flush with cnt = 40 and a pending request -> request not accepted; FLUSH then EMPTY; bit_pos = 0. Async rst mid-stream -> all outputs zero in the same cycle.
